// File: rtl/alu_bit_serial_ctrl_if.sv
// Request/response and 1-bit slice signals of the bit-serial ALU sequencer.
// The slave modport is the sequencer side. The master modport is the requester plus the external slice.
interface alu_bit_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             slice_a;
  logic             slice_b;
  logic             slice_invert;
  logic             slice_cin;
  logic             slice_less;
  logic [5:0]       slice_op;
  logic             slice_out;
  logic             slice_set;
  logic             slice_cout;

  modport slave (
    input  start, funct, src_a, src_b, slice_out, slice_set, slice_cout,
    output busy, done, result, zero, overflow, illegal,
    output slice_a, slice_b, slice_invert, slice_cin, slice_less, slice_op
  );

  modport master (
    output start, funct, src_a, src_b, slice_out, slice_set, slice_cout,
    input  busy, done, result, zero, overflow, illegal,
    input  slice_a, slice_b, slice_invert, slice_cin, slice_less, slice_op
  );
endinterface

// File: rtl/alu_bit_serial_ctrl.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first.
// It supports ADD, SUB, AND, OR and SLT, with a carry flop between cycles.
module alu_bit_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  alu_bit_serial_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opA_q, opB_q, result_q;
  logic [5:0]       funct_q;
  logic [CW-1:0]    k_q;
  logic             carry_q, msbSet_q;
  logic             busy_q, done_q, zero_q, overflow_q, illegal_q;

  logic             sliceA_d, sliceB_d, sliceInv_d, sliceCin_d, sliceLess_d;
  logic [5:0]       sliceOp_d;
  logic [WIDTH-1:0] resultShift_d;
  logic             invert_d, isLast_d, legal_d, addSub_d;

  assign invert_d      = (funct_q == FN_SUB) || (funct_q == FN_SLT);
  assign addSub_d      = (funct_q == FN_ADD) || (funct_q == FN_SUB);
  assign isLast_d      = (k_q == CW'(WIDTH-1));
  assign legal_d       = (bus.funct == FN_AND) || (bus.funct == FN_OR) ||
                         (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                         (bus.funct == FN_SLT);
  assign resultShift_d = {bus.slice_out, result_q[WIDTH-1:1]};

  // Slice controls must track the current bit in the same cycle, so they are combinational.
  always_comb begin
    sliceA_d    = 1'b0;
    sliceB_d    = 1'b0;
    sliceInv_d  = 1'b0;
    sliceCin_d  = 1'b0;
    sliceLess_d = 1'b0;
    sliceOp_d   = FN_AND;
    case (state_q)
      RUN: begin
        sliceA_d   = opA_q[0];
        sliceB_d   = opB_q[0];
        sliceInv_d = invert_d;
        sliceCin_d = (k_q == '0) ? invert_d : carry_q;
        sliceOp_d  = (funct_q == FN_SLT) ? FN_SUB : funct_q;
      end
      FIX: begin
        sliceOp_d   = FN_SLT;
        sliceLess_d = msbSet_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      funct_q    <= '0;
      k_q        <= '0;
      carry_q    <= 1'b0;
      msbSet_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opA_q      <= bus.src_a;
            opB_q      <= bus.src_b;
            funct_q    <= bus.funct;
            k_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= !legal_d;
            busy_q     <= 1'b1;
            if (legal_d) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              zero_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          carry_q  <= bus.slice_cout;
          result_q <= resultShift_d;
          opA_q    <= opA_q >> 1;
          opB_q    <= opB_q >> 1;
          k_q      <= k_q + 1'b1;
          if (isLast_d) begin
            // Signed overflow is the carry into the MSB differing from the carry out of it.
            msbSet_q   <= bus.slice_set;
            overflow_q <= addSub_d & (sliceCin_d ^ bus.slice_cout);
            if (funct_q == FN_SLT) begin
              state_q <= FIX;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              zero_q  <= (resultShift_d == '0);
            end
          end
        end
        FIX: begin
          result_q   <= {{(WIDTH-1){1'b0}}, bus.slice_out};
          overflow_q <= 1'b0;
          zero_q     <= !bus.slice_out;
          done_q     <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.overflow     = overflow_q;
  assign bus.illegal      = illegal_q;
  assign bus.slice_a      = sliceA_d;
  assign bus.slice_b      = sliceB_d;
  assign bus.slice_invert = sliceInv_d;
  assign bus.slice_cin    = sliceCin_d;
  assign bus.slice_less   = sliceLess_d;
  assign bus.slice_op     = sliceOp_d;
endmodule

// File: tb/tb_alu_bit_serial_ctrl.sv
// Directed bench for alu_bit_serial_ctrl with a behavioural 1-bit MIPS-style ALU slice.
module tb_alu_bit_serial_ctrl;
  localparam int WIDTH = 32;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  int          cycles, busyCnt;
  logic        invertOk, timedOut, sawDone;
  logic [31:0] gotResult;
  logic        gotZero, gotOvf, gotIllegal;

  alu_bit_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_bit_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // External slice model: b is inverted and combined with cin for add/sub.
  logic sliceBi, sliceSum;
  always_comb begin
    sliceBi        = bus.slice_b ^ bus.slice_invert;
    sliceSum       = bus.slice_a ^ sliceBi ^ bus.slice_cin;
    bus.slice_set  = sliceSum;
    bus.slice_cout = (bus.slice_a & sliceBi) | (bus.slice_a & bus.slice_cin) |
                     (sliceBi & bus.slice_cin);
    case (bus.slice_op)
      FN_AND:         bus.slice_out = bus.slice_a & sliceBi;
      FN_OR:          bus.slice_out = bus.slice_a | sliceBi;
      FN_ADD, FN_SUB: bus.slice_out = sliceSum;
      FN_SLT:         bus.slice_out = bus.slice_less;
      default:        bus.slice_out = 1'b0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request and wait for done.
  // injectAt > 0 re-asserts start with other operands on that cycle of the run.
  task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a,
                               input logic [31:0] b, input int injectAt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = fn;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    cycles   = 1;
    busyCnt  = 0;
    invertOk = 1'b1;
    timedOut = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      bus.start = (cycles == injectAt);
      if (cycles == injectAt) begin
        bus.funct = FN_SUB;
        bus.src_a = 32'd100;
        bus.src_b = 32'd1;
      end
      if (bus.busy) busyCnt++;
      if (!bus.done && cycles <= WIDTH && !bus.slice_invert) invertOk = 1'b0;
      if (bus.done) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      cycles++;
    end
    bus.start  = 1'b0;
    gotResult  = bus.result;
    gotZero    = bus.zero;
    gotOvf     = bus.overflow;
    gotIllegal = bus.illegal;
    if (timedOut) checkOutput("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.funct = 6'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_result", bus.result, 0);
    checkOutput("reset_slice_op", bus.slice_op, FN_AND);
    rst = 1'b0;

    applyStimulus(FN_ADD, 32'd7, 32'd5, 0);
    checkOutput("add_result", gotResult, 32'd12);
    checkOutput("add_zero", gotZero, 0);
    checkOutput("add_ovf", gotOvf, 0);
    checkOutput("add_latency", cycles, 33);
    checkOutput("add_busy_cycles", busyCnt, 33);

    applyStimulus(FN_SUB, 32'd5, 32'd7, 0);
    checkOutput("sub_neg_result", gotResult, 32'hFFFF_FFFE);
    checkOutput("sub_neg_ovf", gotOvf, 0);

    applyStimulus(FN_SUB, 32'd9, 32'd9, 0);
    checkOutput("sub_zero_result", gotResult, 0);
    checkOutput("sub_zero_flag", gotZero, 1);

    applyStimulus(FN_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    checkOutput("add_ovf_result", gotResult, 32'h8000_0000);
    checkOutput("add_ovf_flag", gotOvf, 1);

    applyStimulus(FN_SLT, 32'hFFFF_FFFD, 32'd2, 0);
    checkOutput("slt_result", gotResult, 1);
    checkOutput("slt_latency", cycles, 34);
    checkOutput("slt_invert_run", invertOk, 1);
    checkOutput("slt_zero", gotZero, 0);

    applyStimulus(FN_SLT, 32'd2, 32'hFFFF_FFFD, 0);
    checkOutput("slt_swap_result", gotResult, 0);
    checkOutput("slt_swap_zero", gotZero, 1);

    applyStimulus(FN_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    checkOutput("and_result", gotResult, 32'hF000_F000);
    applyStimulus(FN_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    checkOutput("or_b2b_result", gotResult, 32'hFFF0_FFF0);
    checkOutput("or_b2b_latency", cycles, 33);

    applyStimulus(FN_ADD, 32'd7, 32'd5, 5);
    checkOutput("ignore_start_result", gotResult, 32'd12);
    checkOutput("ignore_start_latency", cycles, 33);
    repeat (3) @(negedge clk);
    checkOutput("ignore_start_no_queue", bus.busy, 0);

    applyStimulus(6'd0, 32'd3, 32'd4, 0);
    checkOutput("illegal_latency", cycles, 1);
    checkOutput("illegal_result", gotResult, 0);
    checkOutput("illegal_flag", gotIllegal, 1);
    checkOutput("illegal_ovf", gotOvf, 0);

    // Abort an ADD at bit 10 with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = FN_ADD;
    bus.src_a = 32'hFFFF_FFFF;
    bus.src_b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_result", bus.result, 0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_illegal", bus.illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", sawDone, 0);

    applyStimulus(FN_ADD, 32'd1, 32'd1, 0);
    checkOutput("post_reset_add", gotResult, 32'd2);
    checkOutput("post_reset_illegal", gotIllegal, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
